// File: rtl/fetch_pkg.sv
// Shared constants, pointer sizing helper and payload layout for the fetch-stage buffer.
package fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    // Pointer width for a ring of 'depth' entries, never narrower than one bit.
    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_payload_t;

endpackage

// File: rtl/fetch_pipe_buf_sat_counter.sv
// Saturating up-counter; only an asynchronous reset returns it to zero.
module sat_counter
    import fetch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Count up on inc, sticking at the all-ones value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/fetch_pipe_buf.sv
// Fetch-to-decode ring buffer with valid/ready handshakes, hazard stall, redirect flush
// and a saturating held-cycle counter.
module fetch_pipe_buf
    import fetch_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] RESET_VAL = RESET_PC,
    parameter int          CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       stall,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);
    localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VAL);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH-1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CW-1:0]    count_r;

    logic in_ready_s;
    logic out_valid_s;
    logic push_s;
    logic pop_s;
    logic hold_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == LAST_IDX) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Handshake qualifiers; ready/valid come from registered occupancy only.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        if (count_r < CW'(DEPTH)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        if (count_r != {CW{1'b0}}) begin
            out_valid_s = 1'b1;
        end else begin
            out_valid_s = 1'b0;
        end
        push_s = in_valid & in_ready_s & ~flush;
        pop_s  = out_valid_s & out_ready & ~stall;
        hold_s = out_valid_s & (stall | ~out_ready) & ~flush;
    end

    // Entry storage; a flush leaves stale contents in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= RST_DATA;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; flush overrides any simultaneous push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            rd_ptr_r <= pop_s  ? ptr_next(rd_ptr_r) : rd_ptr_r;
            wr_ptr_r <= push_s ? ptr_next(wr_ptr_r) : wr_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hold_s),
        .cnt   (stall_cnt)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: tb/tb_fetch_pipe_buf.sv
// Directed bench: default DEPTH=2 instance plus a DEPTH=3 / CNT_W=2 instance for wrap and saturation.
module tb_fetch_pipe_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv_a = 1'b0, ordy_a = 1'b0, stl_a = 1'b0, fl_a = 1'b0;
    logic [31:0] id_a = 32'h0;
    logic        ir_a, ov_a;
    logic [31:0] od_a;
    logic [1:0]  cnt_a;
    logic [15:0] sc_a;

    logic        iv_b = 1'b0, ordy_b = 1'b0, stl_b = 1'b0, fl_b = 1'b0;
    logic [31:0] id_b = 32'h0;
    logic        ir_b, ov_b;
    logic [31:0] od_b;
    logic [1:0]  cnt_b;
    logic [1:0]  sc_b;

    int n_cmp = 0;
    int n_mis = 0;

    fetch_pipe_buf dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
        .out_valid(ov_a), .out_ready(ordy_a), .out_data(od_a), .stall(stl_a),
        .flush(fl_a), .count(cnt_a), .stall_cnt(sc_a)
    );

    fetch_pipe_buf #(.DEPTH(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
        .out_valid(ov_b), .out_ready(ordy_b), .out_data(od_b), .stall(stl_b),
        .flush(fl_b), .count(cnt_b), .stall_cnt(sc_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check_eq("rst_ov",   64'(ov_a),  64'h0);
        check_eq("rst_ir",   64'(ir_a),  64'h1);
        check_eq("rst_cnt",  64'(cnt_a), 64'h0);
        check_eq("rst_data", 64'(od_a),  64'h0040_0000);
        check_eq("rst_sc",   64'(sc_a),  64'h0);
        rst_n = 1'b1;
        step();

        // Fill and drain with decode blocked
        iv_a = 1'b1; id_a = 32'h100; step();
        check_eq("fill_cnt1", 64'(cnt_a), 64'h1);
        id_a = 32'h104; step();
        check_eq("fill_cnt2", 64'(cnt_a), 64'h2);
        check_eq("fill_ir0",  64'(ir_a),  64'h0);
        check_eq("fill_head", 64'(od_a),  64'h100);
        id_a = 32'h108; step();
        check_eq("refuse_cnt",  64'(cnt_a), 64'h2);
        check_eq("refuse_head", 64'(od_a),  64'h100);
        iv_a = 1'b0; ordy_a = 1'b1; step();
        check_eq("drain_d1", 64'(od_a),  64'h104);
        check_eq("drain_c1", 64'(cnt_a), 64'h1);
        step();
        check_eq("drain_ov", 64'(ov_a),  64'h0);
        check_eq("drain_c0", 64'(cnt_a), 64'h0);
        check_eq("drain_sc", 64'(sc_a),  64'h2);

        // Streaming with decode always ready
        for (int i = 0; i < 8; i++) begin
            iv_a = 1'b1; id_a = 32'h200 + 32'(4 * i); step();
            check_eq($sformatf("strm_d%0d", i), 64'(od_a),  64'(32'h200 + 32'(4 * i)));
            check_eq($sformatf("strm_c%0d", i), 64'(cnt_a), 64'h1);
            check_eq($sformatf("strm_v%0d", i), 64'(ov_a),  64'h1);
        end

        // Asynchronous reset mid-operation drops the live entry
        iv_a = 1'b0;
        rst_n = 1'b0; #1;
        check_eq("mrst_ov", 64'(ov_a),  64'h0);
        check_eq("mrst_c",  64'(cnt_a), 64'h0);
        check_eq("mrst_sc", 64'(sc_a),  64'h0);
        #2 rst_n = 1'b1;

        // Stall holds the head
        iv_a = 1'b1; id_a = 32'h300; step();
        check_eq("post_rst_push", 64'(cnt_a), 64'h1);
        iv_a = 1'b0; stl_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("stall_d%0d", i), 64'(od_a), 64'h300);
        end
        check_eq("stall_sc", 64'(sc_a), 64'h3);
        stl_a = 1'b0; step();
        check_eq("stall_pop_ov", 64'(ov_a), 64'h0);
        check_eq("stall_sc_keep", 64'(sc_a), 64'h3);

        // Flush collides with an offered entry while full
        ordy_a = 1'b0; iv_a = 1'b1; id_a = 32'h3A0; step();
        id_a = 32'h3A4; step();
        check_eq("fl_full", 64'(cnt_a), 64'h2);
        fl_a = 1'b1; id_a = 32'h400; step();
        check_eq("fl_cnt", 64'(cnt_a), 64'h0);
        check_eq("fl_ov",  64'(ov_a),  64'h0);
        check_eq("fl_sc",  64'(sc_a),  64'h4);
        fl_a = 1'b0; iv_a = 1'b0; ordy_a = 1'b1; step();
        check_eq("fl_no400", 64'(ov_a), 64'h0);
        iv_a = 1'b1; id_a = 32'h500; ordy_a = 1'b0; step();
        check_eq("fl_repush", 64'(od_a), 64'h500);
        iv_a = 1'b0;

        // DEPTH=3: fill, saturate counter, drain, then stream across wraps
        iv_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            id_b = 32'h600 + 32'(4 * k); step();
        end
        check_eq("w_full_c",  64'(cnt_b), 64'h3);
        check_eq("w_full_ir", 64'(ir_b),  64'h0);
        iv_b = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check_eq("sat_sc", 64'(sc_b), 64'h3);
        check_eq("w_head0", 64'(od_b), 64'h600);
        ordy_b = 1'b1; step();
        check_eq("w_head1", 64'(od_b), 64'h604);
        step();
        check_eq("w_head2", 64'(od_b), 64'h608);
        step();
        check_eq("w_empty", 64'(ov_b), 64'h0);
        for (int k = 3; k < 10; k++) begin
            iv_b = 1'b1; id_b = 32'h600 + 32'(4 * k); step();
            check_eq($sformatf("wrap_d%0d", k), 64'(od_b),  64'(32'h600 + 32'(4 * k)));
            check_eq($sformatf("wrap_c%0d", k), 64'(cnt_b), 64'h1);
        end
        iv_b = 1'b0; step();
        check_eq("wrap_done", 64'(ov_b), 64'h0);
        check_eq("sat_keep",  64'(sc_b), 64'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
